// File: rtl/mem_boot_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_boot_arbiter_if
//
// Purpose: groups the requester-side and memory-side signals of
// mem_boot_arbiter into one bundle. Signal names keep the _i/_o suffixes
// as seen from the arbiter, so they read the same on both sides.
//
// Modports:
//   slave  - the arbiter itself. It takes requests from m0/m1 and the
//            memory response, and drives grants, responses and the
//            memory request.
//   master - the environment, which drives the requesters and models the
//            memory.
//
// Signal summary:
//   boot_lock_i              only m0 (boot loader) may be granted
//   mX_req/we/addr/wdata/be  requester X command
//   mX_gnt/rvalid/rdata/err  requester X grant and response
//   mem_req/we/addr/wdata/be command to memory
//   mem_gnt/rvalid/rdata     memory grant and read response
//   timeout_o                one-cycle pulse when a read is aborted
// ---------------------------------------------------------------------------
interface mem_boot_arbiter_if;
  logic        boot_lock_i;

  logic        m0_req_i;
  logic        m0_we_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic [3:0]  m0_be_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m0_err_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic [3:0]  m1_be_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic        m1_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        timeout_o;

  modport slave (
    input  boot_lock_i,
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_be_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output timeout_o
  );

  modport master (
    output boot_lock_i,
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_be_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  timeout_o
  );
endinterface

// File: rtl/mem_boot_arbiter.sv
// ---------------------------------------------------------------------------
// mem_boot_arbiter
//
// Purpose: shares one single-outstanding memory port between two
// requesters. m0 is the boot loader. While boot_lock_i is high, only m0
// can win. The arbiter issues the request combinationally from IDLE. If
// memory stalls, it holds the chosen owner and its fields until the grant
// arrives or the owner withdraws. It then routes the read response, or a
// timeout error, back to that owner only.
//
// Parameters:
//   TIMEOUT_CYC - cycles from memory grant to the forced error response
//                 (the response is forced in the TIMEOUT_CYC-th cycle after
//                 the grant cycle if mem_rvalid_i has not arrived)
//
// Ports:
//   clk_sys_i   system clock
//   rst_sys_ni  asynchronous active-low reset; all outputs are held at 0
//               while it is low
//   bus         mem_boot_arbiter_if.slave (requesters + memory + timeout_o)
//
// Optional feature:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//   between m0 and m1 by means of a last-granted pointer. boot_lock_i still
//   forces m0. When undefined, m0 has fixed priority and no pointer exists.
// ---------------------------------------------------------------------------
module mem_boot_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clk_sys_i,
  input  logic               rst_sys_ni,
  mem_boot_arbiter_if.slave  bus
);

  localparam int unsigned    CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic               owner_reg, owner_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CNT_W-1:0]   cnt_inc;

  // Per-requester views of the command inputs, indexed by owner.
  logic [1:0]         req_vec;
  logic [1:0]         we_vec;
  logic [1:0]         elig_vec;
  logic [31:0]        addr_arr  [2];
  logic [31:0]        wdata_arr [2];
  logic [3:0]         be_arr    [2];

  assign req_vec      = {bus.m1_req_i, bus.m0_req_i};
  assign we_vec       = {bus.m1_we_i,  bus.m0_we_i};
  assign addr_arr[0]  = bus.m0_addr_i;
  assign addr_arr[1]  = bus.m1_addr_i;
  assign wdata_arr[0] = bus.m0_wdata_i;
  assign wdata_arr[1] = bus.m1_wdata_i;
  assign be_arr[0]    = bus.m0_be_i;
  assign be_arr[1]    = bus.m1_be_i;

  // The boot lock removes m1 from arbitration but never touches m0.
  assign elig_vec = {bus.m1_req_i & ~bus.boot_lock_i, bus.m0_req_i};

  // -------------------------------------------------------------------------
  // Owner selection in IDLE
  // -------------------------------------------------------------------------
  logic sel_owner;
  logic cur_owner;
  logic mem_req;
  logic gnt_hit;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer holds the last granted requester. Its reset value is m0, so
  // the first contended grant after reset goes to m1.
  logic last_gnt_reg, last_gnt_next;

  always_comb begin
    sel_owner = 1'b0;
    if (elig_vec == 2'b11) begin
      sel_owner = bus.boot_lock_i ? 1'b0 : ~last_gnt_reg;
    end else begin
      sel_owner = elig_vec[1] & ~elig_vec[0];
    end
  end

  assign last_gnt_next = gnt_hit ? cur_owner : last_gnt_reg;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      last_gnt_reg <= 1'b0;
    end else begin
      last_gnt_reg <= last_gnt_next;
    end
  end
`else
  // Fixed priority: m0 wins whenever it is eligible.
  assign sel_owner = elig_vec[1] & ~elig_vec[0];
`endif

  // In IDLE the owner is the freshly selected one. After that it is the
  // latched one, so a late m0 request or a rising boot_lock_i cannot steal
  // a stalled request.
  assign cur_owner = (state_reg == IDLE) ? sel_owner : owner_reg;
  assign cnt_inc   = cnt_reg + CNT_W'(1);

  // -------------------------------------------------------------------------
  // Next-state and response logic
  // -------------------------------------------------------------------------
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_data;
  logic        timeout_pulse;

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    cnt_next      = '0;
    mem_req       = 1'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_data     = 32'h0;
    timeout_pulse = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (|elig_vec) begin
          mem_req    = 1'b1;
          owner_next = sel_owner;
          state_next = bus.mem_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end

      WAIT_GNT: begin
        // The owner may withdraw while stalled. The request then vanishes
        // in the same cycle and no grant is issued.
        if (req_vec[owner_reg]) begin
          mem_req = 1'b1;
          if (bus.mem_gnt_i) begin
            state_next = WAIT_RVALID;
          end
        end else begin
          state_next = IDLE;
        end
      end

      WAIT_RVALID: begin
        cnt_next = cnt_inc;
        // A real response wins over a timeout that lands in the same cycle.
        if (bus.mem_rvalid_i) begin
          resp_valid = 1'b1;
          resp_data  = bus.mem_rdata_i;
          state_next = IDLE;
        end else if (cnt_inc == TIMEOUT_VAL) begin
          resp_valid    = 1'b1;
          resp_err      = 1'b1;
          timeout_pulse = 1'b1;
          state_next    = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign gnt_hit = mem_req & bus.mem_gnt_i;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. All outputs are combinational. They are gated by the reset
  // level, so nothing leaks out while the reset is asserted, even though
  // the request path is combinational from the inputs.
  // -------------------------------------------------------------------------
  logic        out_en;
  logic        mem_req_q;
  logic [1:0]  gnt_vec;
  logic [1:0]  rvalid_vec;
  logic [1:0]  err_vec;
  logic [31:0] rdata_arr [2];

  assign out_en    = rst_sys_ni;
  assign mem_req_q = out_en & mem_req;

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_req_q & we_vec[cur_owner];
  assign bus.mem_addr_o  = mem_req_q ? addr_arr[cur_owner]  : 32'h0;
  assign bus.mem_wdata_o = mem_req_q ? wdata_arr[cur_owner] : 32'h0;
  assign bus.mem_be_o    = mem_req_q ? be_arr[cur_owner]    : 4'h0;
  assign bus.timeout_o   = out_en & timeout_pulse;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign gnt_vec[gi]    = out_en & gnt_hit & (cur_owner == 1'(gi));
    // Responses only occur in WAIT_RVALID, where the latched owner is valid.
    assign rvalid_vec[gi] = out_en & resp_valid & (owner_reg == 1'(gi));
    assign err_vec[gi]    = rvalid_vec[gi] & resp_err;
    assign rdata_arr[gi]  = rvalid_vec[gi] ? resp_data : 32'h0;
  end

  assign bus.m0_gnt_o    = gnt_vec[0];
  assign bus.m0_rvalid_o = rvalid_vec[0];
  assign bus.m0_err_o    = err_vec[0];
  assign bus.m0_rdata_o  = rdata_arr[0];

  assign bus.m1_gnt_o    = gnt_vec[1];
  assign bus.m1_rvalid_o = rvalid_vec[1];
  assign bus.m1_err_o    = err_vec[1];
  assign bus.m1_rdata_o  = rdata_arr[1];

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_boot_arbiter
//
// Directed scenarios followed by a randomized run. Every cycle, the outputs
// are compared against a transaction-level reference model. The model tracks
// which requester has a request stalled at memory, which requester has a
// read in flight, and how many cycles that read has been waiting.
// ---------------------------------------------------------------------------
module tb_mem_boot_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;

  mem_boot_arbiter_if bus ();

  mem_boot_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk_sys_i  (clk),
    .rst_sys_ni (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: transaction view.
  int stall_own = -1;   // requester whose request is waiting for mem grant
  int read_own  = -1;   // requester with a transaction past its grant
  int waited    = 0;    // cycles spent waiting for that response
  int last_win  = 0;    // last granted requester

  // Expected outputs for the current cycle.
  logic        e_req;
  logic [71:0] e_fields;
  logic [1:0]  e_gnt, e_rv, e_err;
  logic [31:0] e_rd [2];
  logic        e_to;
  int          cand;

  // Observed outputs, latched at the sample point for scenario checks.
  logic [1:0]  o_gnt, o_rv, o_err;
  logic [31:0] o_rd [2];
  logic        o_req, o_to;
  logic [31:0] o_addr;

  task automatic check(string tag, logic [71:0] obs, logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick();
    bit e0, e1;
    e0 = bus.m0_req_i;
    e1 = bus.m1_req_i && !bus.boot_lock_i;
    if (e0 && e1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return 1 - last_win;
`else
      return 0;
`endif
    end
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic bit req_of(int c);
    return (c == 0) ? bus.m0_req_i : bus.m1_req_i;
  endfunction

  function automatic logic [71:0] fields_of(int c);
    if (c == 0) return {3'b0, bus.m0_we_i, bus.m0_be_i, bus.m0_addr_i, bus.m0_wdata_i};
    return {3'b0, bus.m1_we_i, bus.m1_be_i, bus.m1_addr_i, bus.m1_wdata_i};
  endfunction

  // One clock cycle: inputs are already driven. Evaluate, compare, advance
  // the model, then move to just after the next rising edge.
  task automatic cycle();
    #4;
    e_req = 0; e_fields = '0; e_gnt = 0; e_rv = 0; e_err = 0;
    e_rd[0] = 0; e_rd[1] = 0; e_to = 0; cand = -1;
    if (rst_n) begin
      if (read_own >= 0) begin
        if (bus.mem_rvalid_i) begin
          e_rv[read_own] = 1'b1;
          e_rd[read_own] = bus.mem_rdata_i;
        end else if (waited + 1 == TO) begin
          e_rv[read_own]  = 1'b1;
          e_err[read_own] = 1'b1;
          e_to = 1'b1;
        end
      end else begin
        cand = (stall_own >= 0) ? stall_own : pick();
        if (cand >= 0 && req_of(cand)) begin
          e_req = 1'b1;
          e_fields = fields_of(cand);
          if (bus.mem_gnt_i) e_gnt[cand] = 1'b1;
        end
      end
    end

    o_gnt = {bus.m1_gnt_o, bus.m0_gnt_o};
    o_rv  = {bus.m1_rvalid_o, bus.m0_rvalid_o};
    o_err = {bus.m1_err_o, bus.m0_err_o};
    o_rd[0] = bus.m0_rdata_o;
    o_rd[1] = bus.m1_rdata_o;
    o_req = bus.mem_req_o;
    o_to  = bus.timeout_o;
    o_addr = bus.mem_addr_o;

    check("mem_req", 72'(o_req), 72'(e_req));
    if (e_req || !rst_n)
      check("mem_fields", {3'b0, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o}, e_fields);
    check("gnt", 72'(o_gnt), 72'(e_gnt));
    check("rvalid", 72'(o_rv), 72'(e_rv));
    check("err", 72'(o_err), 72'(e_err));
    check("m0_rdata", 72'(o_rd[0]), 72'(e_rd[0]));
    check("m1_rdata", 72'(o_rd[1]), 72'(e_rd[1]));
    check("timeout", 72'(o_to), 72'(e_to));

    if (!rst_n) begin
      stall_own = -1; read_own = -1; waited = 0; last_win = 0;
    end else if (read_own >= 0) begin
      if (e_rv != 2'b00) read_own = -1;
      else waited++;
    end else if (e_req) begin
      if (e_gnt != 2'b00) begin
        read_own = cand; waited = 0; stall_own = -1; last_win = cand;
      end else begin
        stall_own = cand;
      end
    end else begin
      stall_own = -1;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.boot_lock_i = 0;
    bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_addr_i = 0; bus.m0_wdata_i = 0; bus.m0_be_i = 0;
    bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = 0; bus.m1_wdata_i = 0; bus.m1_be_i = 0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
  endtask

  initial begin
    int g0, g1, prev, alt_ok, hit_k, to_cnt, req_cnt;
    logic err_at_hit;
    logic [31:0] rd_at_hit;

    // ---- Reset: outputs must stay 0 even with active inputs ----
    idle_inputs();
    rst_n = 0;
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h1234; bus.m0_be_i = 4'hF;
    bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hFFFF_0000;
    cycle();
    cycle();
    check("rst_req", 72'(o_req), 72'd0);
    idle_inputs();
    rst_n = 1;
    cycle();
    $display("step reset done");

    // ---- Single access from m1 ----
    bus.m1_req_i = 1; bus.m1_we_i = 1; bus.m1_addr_i = 32'h100;
    bus.m1_wdata_i = 32'hDEADBEEF; bus.m1_be_i = 4'hF; bus.mem_gnt_i = 1;
    cycle();
    check("s1_m1_gnt", 72'({o_req, o_gnt}), 72'(3'b110));
    check("s1_addr", 72'(o_addr), 72'(32'h100));
    idle_inputs();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hCAFE_0001;
    cycle();
    check("s1_rvalid", 72'(o_rv), 72'(2'b10));
    check("s1_rdata", 72'(o_rd[1]), 72'(32'hCAFE_0001));
    idle_inputs();
    cycle();
    $display("step single access done");

    // ---- Contention with gnt/rvalid always high ----
    bus.m0_req_i = 1; bus.m1_req_i = 1; bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1;
    bus.m0_addr_i = 32'hA0; bus.m1_addr_i = 32'hA1;
    g0 = 0; g1 = 0; prev = -1; alt_ok = 1;
    for (int i = 0; i < 12; i++) begin
      bus.mem_rdata_i = $urandom;
      cycle();
      if (o_gnt[0]) begin g0++; if (prev == 0) alt_ok = 0; prev = 0; end
      if (o_gnt[1]) begin g1++; if (prev == 1) alt_ok = 0; prev = 1; end
    end
    check("cont_total", 72'(g0 + g1), 72'd6);
`ifdef ARB_ROUND_ROBIN_EN
    check("cont_alternate", 72'(alt_ok), 72'd1);
`else
    check("cont_m1_grants", 72'(g1), 72'd0);
`endif
    idle_inputs();
    cycle();
    $display("step contention done g0=%0d g1=%0d", g0, g1);

    // ---- Boot lock blocks m1 ----
    bus.boot_lock_i = 1; bus.m1_req_i = 1; bus.m1_addr_i = 32'h200; bus.mem_gnt_i = 1;
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      req_cnt += int'(o_req) + int'(o_gnt[1]);
    end
    check("lock_no_req", 72'(req_cnt), 72'd0);
    bus.boot_lock_i = 0;
    cycle();
    check("lock_release_gnt", 72'(o_gnt), 72'(2'b10));
    idle_inputs();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h5;
    cycle();
    idle_inputs();
    cycle();
    $display("step boot lock done");

    // ---- Grant stall: m0 arriving later must not steal ----
    bus.m1_req_i = 1; bus.m1_addr_i = 32'h300; bus.m0_addr_i = 32'h400;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) bus.m0_req_i = 1;
      cycle();
      check("stall_addr", 72'(o_addr), 72'(32'h300));
    end
    bus.mem_gnt_i = 1;
    cycle();
    check("stall_gnt", 72'(o_gnt), 72'(2'b10));
    idle_inputs();
    bus.mem_rvalid_i = 1;
    cycle();
    idle_inputs();
    cycle();
    $display("step grant stall done");

    // ---- Timeout: no response ----
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h500; bus.mem_gnt_i = 1;
    cycle();
    idle_inputs();
    hit_k = -1; to_cnt = 0; err_at_hit = 0; rd_at_hit = 32'hX;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (o_rv[0] && hit_k < 0) begin hit_k = k; err_at_hit = o_err[0]; rd_at_hit = o_rd[0]; end
      to_cnt += int'(o_to);
    end
    check("to_cycle", 72'(hit_k), 72'(TO));
    check("to_err", 72'(err_at_hit), 72'd1);
    check("to_rdata", 72'(rd_at_hit), 72'd0);
    check("to_pulses", 72'(to_cnt), 72'd1);
    $display("step timeout done hit=%0d", hit_k);

    // ---- Response exactly at the timeout cycle wins ----
    bus.m1_req_i = 1; bus.m1_addr_i = 32'h600; bus.mem_gnt_i = 1;
    cycle();
    idle_inputs();
    for (int k = 1; k <= TO; k++) begin
      if (k == TO) begin bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1357_9BDF; end
      cycle();
    end
    check("race_rv", 72'({o_rv, o_err, o_to}), 72'(5'b10_00_0));
    check("race_rdata", 72'(o_rd[1]), 72'(32'h1357_9BDF));
    idle_inputs();
    cycle();
    $display("step timeout race done");

    // ---- Reset in WAIT_RVALID ----
    bus.m1_req_i = 1; bus.m1_addr_i = 32'h700; bus.mem_gnt_i = 1;
    cycle();
    idle_inputs();
    rst_n = 0;
    cycle();
    rst_n = 1;
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h7777;
    cycle();
    check("rst_late_rv", 72'(o_rv), 72'd0);
    idle_inputs();
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h800; bus.mem_gnt_i = 1;
    cycle();
    check("rst_next_gnt", 72'(o_gnt), 72'(2'b01));
    idle_inputs();
    bus.mem_rvalid_i = 1;
    cycle();
    idle_inputs();
    cycle();
    $display("step reset mid-transaction done");

    // ---- Randomized run against the model ----
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 5) bus.boot_lock_i = ~bus.boot_lock_i;
      bus.m0_req_i   = ($urandom_range(99) < 45);
      bus.m1_req_i   = ($urandom_range(99) < 60);
      bus.m0_we_i    = $urandom_range(1);
      bus.m1_we_i    = $urandom_range(1);
      bus.m0_addr_i  = $urandom;  bus.m1_addr_i  = $urandom;
      bus.m0_wdata_i = $urandom;  bus.m1_wdata_i = $urandom;
      bus.m0_be_i    = 4'($urandom_range(15));
      bus.m1_be_i    = 4'($urandom_range(15));
      bus.mem_gnt_i    = ($urandom_range(99) < 50);
      bus.mem_rvalid_i = ($urandom_range(99) < 12);
      bus.mem_rdata_i  = $urandom;
      rst_n = ($urandom_range(999) >= 5);
      cycle();
    end
    rst_n = 1;
    idle_inputs();
    cycle();
    $display("step random run done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_boot_arbiter.md
MEM_BOOT_ARBITER -- requirements
Module: mem_boot_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: maximum cycles from memory grant to mem_rvalid_i before the arbiter raises a timeout.
REQ-002 SHALL have ports clk_sys_i (in, 1, system clock) and rst_sys_ni (in, 1, reset), with reset rst_sys_ni asynchronous, active-low, and clock clk_sys_i.
REQ-003 SHALL have boot_lock_i (in, 1): when high, only requester M0 (boot loader) is eligible.
REQ-004 SHALL have, for each requester m0 and m1, these ports:
- mX_req_i (in, 1);
- mX_we_i (in, 1);
- mX_addr_i (in, 32);
- mX_wdata_i (in, 32);
- mX_be_i (in, 4);
- mX_gnt_o (out, 1);
- mX_rvalid_o (out, 1);
- mX_rdata_o (out, 32);
- mX_err_o (out, 1).
REQ-005 SHALL have memory-side ports mem_req_o (out, 1), mem_we_o (out, 1), mem_addr_o (out, 32), mem_wdata_o (out, 32), mem_be_o (out, 4), mem_gnt_i (in, 1), mem_rvalid_i (in, 1) and mem_rdata_i (in, 32).
REQ-006 SHALL have timeout_o (out, 1): one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT_GNT and WAIT_RVALID, with at most one outstanding memory transaction.
REQ-008 SHALL compute eligibility as follows:
- M0 is eligible when m0_req_i is high.
- M1 is eligible when m1_req_i is high and boot_lock_i is low.
REQ-009 In IDLE with any eligible requester, SHALL select an owner and drive mem_req_o=1 combinationally in the same cycle, with mem_we/addr/wdata/be muxed from the owner.
REQ-010 On simultaneous M0 and M1 eligibility, SHALL give M0 the grant (fixed priority) unless REQ-024 applies.
REQ-011 If mem_gnt_i=1 while mem_req_o=1, SHALL pulse the owner's mX_gnt_o in the same cycle and enter WAIT_RVALID with the owner latched.
REQ-012 If mem_gnt_i=0 in IDLE, SHALL latch the owner and enter WAIT_GNT.
REQ-013 In WAIT_GNT, SHALL keep the owner fixed and keep mem_req_o=1 with the owner's fields, even if the other requester becomes eligible or boot_lock_i rises.
REQ-014 If the owner drops mX_req_i in WAIT_GNT, SHALL deassert mem_req_o and return to IDLE next cycle without issuing mX_gnt_o.
REQ-015 In WAIT_RVALID, SHALL hold mem_req_o=0 and never assert any mX_gnt_o.
REQ-016 When mem_rvalid_i=1 in WAIT_RVALID, SHALL route the response to the latched owner only: owner's mX_rvalid_o=1 and mX_rdata_o=mem_rdata_i in the same cycle, then return to IDLE.
REQ-017 From IDLE after completion, a new request SHALL be issued no earlier than the cycle after mX_rvalid_o.
REQ-018 SHALL drive a non-owner's mX_rvalid_o and mX_err_o to 0 and its mX_rdata_o to 32'h0.
REQ-019 SHALL run a timeout counter as follows:
- Width is $clog2(TIMEOUT_CYC+1).
- Cleared on entry to WAIT_RVALID.
- Incremented each cycle in WAIT_RVALID.
- When it reaches TIMEOUT_CYC without mem_rvalid_i, the block pulses owner mX_rvalid_o=1, mX_err_o=1, mX_rdata_o=32'h0 and timeout_o=1, then returns to IDLE.
REQ-020 When mem_rvalid_i and the timeout occur in the same cycle, SHALL treat mem_rvalid_i as winning: normal response, no error, no timeout_o.
REQ-021 SHALL ignore mem_rvalid_i arriving in IDLE or WAIT_GNT (no mX_rvalid_o).
REQ-022 SHALL tie mem_gnt_i behaviour as follows: all grants are combinational from mem_gnt_i; all other outputs (mX_rvalid_o, mX_rdata_o, mX_err_o, timeout_o, mem_*) are combinational from state and inputs, with no extra latency.

Reset
REQ-023 While rst_sys_ni=0, the block SHALL:
- hold state=IDLE, latched owner=M0, timeout counter=0, round-robin pointer=M0;
- hold all outputs at 0, including mem_addr_o, mem_wdata_o, mem_be_o and rdata;
- on reset mid-transaction, discard the outstanding transaction with no rvalid issued.

Configuration
REQ-024 With macro ARB_ROUND_ROBIN_EN defined, SHALL resolve simultaneous eligibility as follows:
- A 1-bit pointer records the last granted requester, updated on each mX_gnt_o.
- The requester not last granted wins.
- When boot_lock_i=1, M0 always wins.
REQ-025 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority M0 > M1 and have no pointer register.

Verification
REQ-026 SHALL pass this scenario: single access. m1 write addr 0x100, wdata 0xDEADBEEF, be 0xF, mem_gnt_i=1 -> mem_req_o and m1_gnt_o same cycle. mem_rvalid_i next cycle -> m1_rvalid_o=1, m0_rvalid_o=0.
REQ-027 SHALL pass this scenario: contention. m0 and m1 requesting every cycle, gnt/rvalid always 1 -> without macro, m0 gets all grants; with ARB_ROUND_ROBIN_EN, grants alternate m0, m1, m0, m1.
REQ-028 SHALL pass this scenario: boot lock. boot_lock_i=1, only m1 requesting for 10 cycles -> mem_req_o=0 and no m1_gnt_o. Drop lock -> m1 is granted.
REQ-029 SHALL pass this scenario: grant stall. m1 requesting, mem_gnt_i=0 for 3 cycles, m0 raises req at cycle 1 -> mem_addr_o stays at m1's address. m1_gnt_o is asserted when gnt=1.
REQ-030 SHALL pass this scenario: timeout. After a grant, mem_rvalid_i never arrives -> at TIMEOUT_CYC=16 cycles, owner rvalid=1, err=1, rdata=0 and timeout_o pulses once. A second case with rvalid arriving on exactly cycle 16 completes with err=0.
REQ-031 SHALL pass this scenario: reset in WAIT_RVALID. rst_sys_ni is pulsed low for 1 cycle -> outputs go 0, the late mem_rvalid_i is ignored, and the next request proceeds normally.
